// File: rtl/vx_bits_remove_stage.sv
// vx_bits_remove_stage
// Elastic two-entry pipeline stage that strips an S-bit field out of each of
// LANES N-bit words at a per-lane runtime position. The compacted word and the
// removed field are registered together. A main register plus one skid
// register give one beat per cycle under backpressure, and ready_in never
// depends combinationally on ready_out.
//
// Optional feature: define VX_BITS_REMOVE_PERF_EN to add the perf_xfers and
// perf_stalls counters and their output ports.

module vx_bits_remove_stage #(
  parameter int N     = 8,
  parameter int S     = 1,
  parameter int LANES = 1,
  localparam int POSW_RAW = $clog2(N - S + 1),
  localparam int POSW     = (POSW_RAW < 1) ? 1 : POSW_RAW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [LANES*N-1:0]       data_in,
  input  logic [LANES*POSW-1:0]    pos_in,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [LANES*(N-S)-1:0]   data_out,
  output logic [LANES*S-1:0]       removed_out,
  output logic                     pos_err
`ifdef VX_BITS_REMOVE_PERF_EN
  ,
  output logic [31:0]              perf_xfers,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int DW = LANES * (N - S);
  localparam int RW = LANES * S;
  localparam logic [POSW-1:0] POS_MAX = POSW'(N - S);

  // Parameter legality is checked at elaboration time.
  if (N < 2) begin : g_bad_n
    $error("vx_bits_remove_stage: N must be at least 2");
  end
  if ((S < 1) || (S >= N)) begin : g_bad_s
    $error("vx_bits_remove_stage: S must satisfy 1 <= S < N");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("vx_bits_remove_stage: LANES must be at least 1");
  end

  // Occupancy encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t state, state_next;

  logic main_valid;
  logic skid_valid;
  logic in_xfer;
  logic out_xfer;

  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  logic [DW-1:0] ext_data;
  logic [RW-1:0] ext_rem;
  logic [LANES-1:0] lane_err;
  logic ext_err;

  logic [DW-1:0] main_data;
  logic [RW-1:0] main_rem;
  logic [DW-1:0] skid_data;
  logic [RW-1:0] skid_rem;
  logic skid_err;
  logic pos_err_q;

  assign main_valid = state[1];
  assign skid_valid = state[0];

  // Ready only follows skid occupancy; reset forces both handshakes low so no
  // transfer on either side can happen in a reset cycle.
  assign ready_in  = !skid_valid && !reset;
  assign valid_out = main_valid && !reset;
  assign in_xfer   = valid_in && ready_in;
  assign out_xfer  = valid_out && ready_out;

  assign data_out    = main_data;
  assign removed_out = main_rem;
  assign pos_err     = pos_err_q;

  // Per-lane extraction happens before the registers: the low p bits stay in
  // place, the bits above the field drop down by S, and the field itself is
  // returned separately. Positions beyond N-S clamp to the top field.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N-1:0]    word;
    logic [POSW-1:0] lane_pos;
    logic [POSW-1:0] eff_pos;
    logic            over;

    assign word     = data_in[i*N +: N];
    assign lane_pos = pos_in[i*POSW +: POSW];
    assign over     = (lane_pos > POS_MAX);
    assign eff_pos  = over ? POS_MAX : lane_pos;

    assign ext_data[i*(N-S) +: (N-S)] =
      (N-S)'(((word >> (eff_pos + S)) << eff_pos) |
             (word & ((N'(1) << eff_pos) - N'(1))));
    assign ext_rem[i*S +: S] = S'(word >> eff_pos);
    assign lane_err[i] = over;
  end

  assign ext_err = |lane_err;

  // Occupancy register; reset drops any buffered beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next occupancy and which register loads from where this cycle.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Payload registers. The skid entry carries its own range-error bit so the
  // sticky flag rises only when that beat reaches the main register.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_rem  <= '0;
      skid_data <= '0;
      skid_rem  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= ext_data;
        main_rem  <= ext_rem;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_rem  <= skid_rem;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_rem  <= ext_rem;
        skid_err  <= ext_err;
      end
    end
  end

  // Sticky range-error flag, set when an offending beat lands in main.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_err_q <= 1'b0;
    end else if ((load_main_in && ext_err) || (load_main_skid && skid_err)) begin
      pos_err_q <= 1'b1;
    end
  end

`ifdef VX_BITS_REMOVE_PERF_EN
  logic [31:0] xfer_count;
  logic [31:0] stall_count;

  assign perf_xfers  = xfer_count;
  assign perf_stalls = stall_count;

  // Free-running wrap-around counters of output transfers and stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (out_xfer) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (valid_out && !ready_out) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_bits_remove_stage.sv
// tb_vx_bits_remove_stage
// Directed, table-driven bench for vx_bits_remove_stage with N=8, S=2,
// LANES=4. Expected compacted words and removed fields are hand-computed.
// With VX_BITS_REMOVE_PERF_EN defined, the perf counters are checked as well.

module tb_vx_bits_remove_stage;

  localparam int N     = 8;
  localparam int S     = 2;
  localparam int LANES = 4;
  localparam int POSW  = 3;

  typedef struct {
    logic [LANES*N-1:0]     data;
    logic [LANES*POSW-1:0]  pos;
    logic [LANES*(N-S)-1:0] exp_data;
    logic [LANES*S-1:0]     exp_rem;
  } vec_t;

  logic clk;
  logic reset;
  logic valid_in;
  logic ready_in;
  logic [LANES*N-1:0] data_in;
  logic [LANES*POSW-1:0] pos_in;
  logic valid_out;
  logic ready_out;
  logic [LANES*(N-S)-1:0] data_out;
  logic [LANES*S-1:0] removed_out;
  logic pos_err;
`ifdef VX_BITS_REMOVE_PERF_EN
  logic [31:0] perf_xfers;
  logic [31:0] perf_stalls;
`endif

  int assert_count = 0;
  int fail_count   = 0;
  vec_t vecs [5];

  vx_bits_remove_stage #(.N(N), .S(S), .LANES(LANES)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .data_in     (data_in),
    .pos_in      (pos_in),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .removed_out (removed_out),
    .pos_err     (pos_err)
`ifdef VX_BITS_REMOVE_PERF_EN
    ,
    .perf_xfers  (perf_xfers),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int idx);
    valid_in = v;
    data_in  = vecs[idx].data;
    pos_in   = vecs[idx].pos;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int idx);
    checkOutput({tag, " valid_out"}, 64'(valid_out), 64'd1);
    checkOutput({tag, " data_out"}, 64'(data_out), 64'(vecs[idx].exp_data));
    checkOutput({tag, " removed_out"}, 64'(removed_out), 64'(vecs[idx].exp_rem));
  endtask

  initial begin
    // Lane 0 is the rightmost element of each concatenation.
    vecs[0] = '{data: {8'h5A, 8'hB6, 8'hB6, 8'hB6},
                pos: {3'd2, 3'd6, 3'd0, 3'd3},
                exp_data: {6'h16, 6'h36, 6'h2D, 6'h2E},
                exp_rem: {2'b10, 2'b10, 2'b10, 2'b10}};
    vecs[1] = '{data: {8'hFF, 8'hC3, 8'h3C, 8'h81},
                pos: {3'd0, 3'd5, 3'd4, 3'd1},
                exp_data: {6'h3F, 6'h23, 6'h0C, 6'h21},
                exp_rem: {2'b11, 2'b10, 2'b11, 2'b00}};
    vecs[2] = '{data: {8'hB6, 8'h81, 8'hFF, 8'h00},
                pos: {3'd0, 3'd1, 3'd3, 3'd6},
                exp_data: {6'h2D, 6'h21, 6'h3F, 6'h00},
                exp_rem: {2'b10, 2'b00, 2'b11, 2'b00}};
    vecs[3] = '{data: {8'hC3, 8'hB6, 8'h5A, 8'h3C},
                pos: {3'd5, 3'd3, 3'd2, 3'd4},
                exp_data: {6'h23, 6'h2E, 6'h16, 6'h0C},
                exp_rem: {2'b10, 2'b10, 2'b10, 2'b11}};
    vecs[4] = '{data: {8'hB6, 8'hB6, 8'hB6, 8'hB6},
                pos: {3'd7, 3'd6, 3'd7, 3'd6},
                exp_data: {6'h36, 6'h36, 6'h36, 6'h36},
                exp_rem: {2'b10, 2'b10, 2'b10, 2'b10}};

    // Reset state
    reset = 1'b1;
    ready_out = 1'b1;
    applyStimulus(1'b0, 0);
    tick();
    tick();
    checkOutput("reset valid_out", 64'(valid_out), 64'd0);
    checkOutput("reset ready_in", 64'(ready_in), 64'd0);
    checkOutput("reset data_out", 64'(data_out), 64'd0);
    checkOutput("reset removed_out", 64'(removed_out), 64'd0);
    checkOutput("reset pos_err", 64'(pos_err), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("release ready_in", 64'(ready_in), 64'd1);

    // Sixteen back-to-back beats at full throughput
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, i % 4);
      tick();
      checkBeat($sformatf("stream%0d", i), i % 4);
      checkOutput($sformatf("stream%0d ready_in", i), 64'(ready_in), 64'd1);
    end
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("stream drain valid_out", 64'(valid_out), 64'd0);
    checkOutput("stream pos_err", 64'(pos_err), 64'd0);

    // Backpressure: A and B fill both entries, C waits for ready_in
    ready_out = 1'b0;
    applyStimulus(1'b1, 0);
    tick();
    checkBeat("stallA", 0);
    checkOutput("stallA ready_in", 64'(ready_in), 64'd1);
    applyStimulus(1'b1, 1);
    tick();
    checkBeat("stallB hold A", 0);
    checkOutput("stallB ready_in", 64'(ready_in), 64'd0);
    applyStimulus(1'b1, 4);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkBeat($sformatf("stall hold%0d", i), 0);
      checkOutput($sformatf("stall hold%0d ready_in", i), 64'(ready_in), 64'd0);
      checkOutput($sformatf("stall hold%0d pos_err", i), 64'(pos_err), 64'd0);
    end
    applyStimulus(1'b1, 2);
    ready_out = 1'b1;
    tick();
    checkBeat("release B", 1);
    checkOutput("release ready_in", 64'(ready_in), 64'd1);
    tick();
    checkBeat("release C", 2);
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("release drain valid_out", 64'(valid_out), 64'd0);
    checkOutput("release pos_err", 64'(pos_err), 64'd0);

    // Out-of-range position clamps and sets the sticky error
    applyStimulus(1'b1, 4);
    tick();
    checkBeat("clamp", 4);
    checkOutput("clamp pos_err", 64'(pos_err), 64'd1);
    applyStimulus(1'b1, 0);
    tick();
    checkBeat("after clamp", 0);
    checkOutput("sticky pos_err", 64'(pos_err), 64'd1);
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("sticky idle pos_err", 64'(pos_err), 64'd1);

    // Reset while both entries are occupied
    ready_out = 1'b0;
    applyStimulus(1'b1, 1);
    tick();
    applyStimulus(1'b1, 3);
    tick();
    checkOutput("two ready_in", 64'(ready_in), 64'd0);
    applyStimulus(1'b0, 0);
    reset = 1'b1;
    #1;
    checkOutput("reset cycle valid_out", 64'(valid_out), 64'd0);
    tick();
    checkOutput("midreset valid_out", 64'(valid_out), 64'd0);
    checkOutput("midreset ready_in", 64'(ready_in), 64'd0);
    checkOutput("midreset pos_err", 64'(pos_err), 64'd0);
    checkOutput("midreset data_out", 64'(data_out), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("midreset release ready_in", 64'(ready_in), 64'd1);
    ready_out = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("no stale%0d valid_out", i), 64'(valid_out), 64'd0);
    end

`ifdef VX_BITS_REMOVE_PERF_EN
    // Five transfers and three stalled cycles
    checkOutput("perf xfers start", 64'(perf_xfers), 64'd0);
    checkOutput("perf stalls start", 64'(perf_stalls), 64'd0);
    ready_out = 1'b0;
    applyStimulus(1'b1, 0);
    tick();
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("perf stalls mid", 64'(perf_stalls), 64'd3);
    checkOutput("perf xfers mid", 64'(perf_xfers), 64'd0);
    ready_out = 1'b1;
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1'b1, i % 4);
      tick();
    end
    applyStimulus(1'b0, 0);
    tick();
    checkOutput("perf drain valid_out", 64'(valid_out), 64'd0);
    checkOutput("perf xfers", 64'(perf_xfers), 64'd5);
    checkOutput("perf stalls", 64'(perf_stalls), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("perf xfers reset", 64'(perf_xfers), 64'd0);
    checkOutput("perf stalls reset", 64'(perf_stalls), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/vx_bits_remove_stage.md
Name: vx_bits_remove_stage

Overview:
- Elastic, handshaked pipeline stage that removes an S-bit field from each of LANES data words.
- Field position is selected per lane at runtime; the static-position remove is a fixed special case of this block.
- The removed field is returned alongside the compacted word.
- Sits between issue/commit pipeline stages where packed tags or metadata fields are stripped from payloads.
- A 2-entry skid buffer sustains full throughput under backpressure.

Parameters:
- N, 8: input word width per lane; N >= 2.
- S, 1: removed field width; 1 <= S < N (static assert).
- LANES, 1: independent lanes sharing one handshake; LANES >= 1.
- POSW, derived = max(1, $clog2(N-S+1)): width of each lane's position field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  input beat valid.
- ready_in  out  1  stage can accept a beat.
- data_in  in  LANES*N  lane i occupies bits [i*N +: N].
- pos_in  in  LANES*POSW  lane i removal LSB position, bits [i*POSW +: POSW].
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accepts.
- data_out  out  LANES*(N-S)  compacted words, lane i at [i*(N-S) +: N-S].
- removed_out  out  LANES*S  removed fields, lane i at [i*S +: S].
- pos_err  out  1  sticky flag: some accepted beat had an out-of-range pos.

Behaviour:
- Transfer rules:
  - Input transfer when valid_in && ready_in.
  - Output transfer when valid_out && ready_out.
  - data_out/removed_out are stable while valid_out=1 && ready_out=0.
- Per-lane function, with p = effective pos:
  - data_out = {data_in[N-1:p+S], data_in[p-1:0]}.
  - p=0: data_out = data_in[N-1:S].
  - p=N-S: data_out = data_in[N-S-1:0].
  - removed_out = data_in[p+S-1:p].
- Range check: if pos_in lane value > N-S, p is clamped to N-S for that lane, and pos_err is set on that accepted beat.
- pos_err:
  - Sticky until reset; it is never set by beats that are not accepted.
  - It is asserted the same cycle the offending beat appears at the main register (valid_out).
- Latency:
  - 1 cycle from input transfer to valid_out when the stage is empty.
  - Full throughput: 1 beat/cycle when ready_out=1.
- Storage: a main output register plus one skid register; extraction is done before registering.
  - ready_in = !skid_valid (registered, not combinational from ready_out).
- States, encoded as {main_valid, skid_valid}:
  - EMPTY (00): accepting a beat -> ONE.
  - ONE (10):
    - Input accepted and output accepted -> ONE (main replaced).
    - Input accepted and output not accepted -> TWO (beat to skid).
    - Output accepted only -> EMPTY.
  - TWO (11): ready_in=0.
    - Output accepted -> skid moves to main -> ONE.
- Ordering: beats leave strictly in acceptance order. Skid contents are never overwritten.
- Reset:
  - valid_out=0, ready_in=0 while reset is high; ready_in=1 the first cycle after release.
  - pos_err=0; data_out/removed_out are 0.
- Reset mid-operation discards both buffered beats. No output transfer occurs in the reset cycle.
- Simultaneous input and output transfer in ONE keeps occupancy unchanged, with no bubble.

Optional Feature:
- Macro: VX_BITS_REMOVE_PERF_EN.
- When defined, the block adds two outputs:
  - perf_xfers [31:0]: counts output transfers.
  - perf_stalls [31:0]: counts cycles with valid_out && !ready_out.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- N=8,S=2,LANES=1, data_in=0xB6:
  - pos=3 -> data_out=0x2E, removed_out=2'b10, one cycle later.
  - pos=0 -> 0x2D, removed 2'b10.
  - pos=6 -> 0x36, removed 2'b10.
- pos=7 with N=8,S=2 -> clamped to 6: data_out=0x36, pos_err=1 and stays 1 after further valid beats until reset.
- LANES=4, different pos per lane, continuous valid_in with ready_out=1 for 16 beats -> 16 outputs on consecutive cycles, in order, each lane correct.
- Hold ready_out=0 after beats A,B accepted -> ready_in drops to 0, data_out holds A.
  - Release ready_out -> A then B on consecutive cycles; beat C presented during stall is not accepted until ready_in=1.
- Assert reset while in TWO state -> next cycle valid_out=0, pos_err=0, ready_in=1 after release; no stale beat emitted.
- With VX_BITS_REMOVE_PERF_EN: 5 transfers plus 3 stalled cycles -> perf_xfers=5, perf_stalls=3; reset -> both 0.
